// File: rtl/vdma_addr_pkg.sv
// Shared definitions for the VDMA frame address sequencer.
//   state_t    : sequencer state (IDLE = waiting for new_frame, RUN = frame active)
//   DEF_ASIZE  : default address width
//   DEF_LSIZE  : default line counter width
//   DEF_IWIDTH : default frame index width
package vdma_addr_pkg;

  localparam int DEF_ASIZE  = 29;
  localparam int DEF_LSIZE  = 12;
  localparam int DEF_IWIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/edge_generator.sv
// Single-cycle edge detector on a level input.
//   clock : system clock
//   rst_n : asynchronous active-low reset (history register cleared)
//   level : level input to watch
//   pulse : combinational one-cycle pulse on the selected edge
// MODE "NORMAL" detects rising edges (level & ~level_d); any other value
// detects falling edges. The pulse is combinational so the consumer can act
// on the same clock edge that first samples the new level.
module edge_generator #(
  parameter string MODE = "NORMAL"
) (
  input  logic clock,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  generate
    if (MODE == "NORMAL") begin : g_rise
      assign pulse = level & ~level_d;
    end else begin : g_fall
      assign pulse = ~level & level_d;
    end
  endgenerate

endmodule

// File: rtl/frame_ring_addr.sv
// Multi-buffer frame address sequencer for the VDMA burst engines.
// Produces the burst start address for every burst of every line, stepping
// lines by line_stride and frames around a ring of FRAME_NUM buffers
// (or holding a parked buffer).
//
// Ports:
//   clock        : system clock
//   rst_n        : asynchronous active-low reset
//   new_frame    : level; rising edge starts (IDLE) or resyncs (RUN) a frame
//   baseaddr     : address of buffer 0
//   frame_stride : distance between consecutive buffers
//   line_stride  : distance between line starts
//   vlines       : lines per frame, 0 behaves as 1
//   park         : hold the ring at park_index
//   park_index   : parked buffer, clamped to FRAME_NUM-1
//   burst_done   : level; rising edge = one full burst finished
//   tail_done    : level; rising edge = last (partial) burst of a line finished
//   out_addr     : current burst start address
//   frame_index  : buffer index of the current/next frame
//   line_cnt     : completed lines in the current frame
//   busy         : high while in RUN
//   frame_done   : one-cycle pulse after the last line completes
//
// Handshake: every event is the rising edge of its level input; a level held
// high counts once, and the input must drop low between two events. Edges
// are acted on at the clock edge that first samples them high. When several
// edges coincide, new_frame beats tail_done beats burst_done and the losers
// are discarded.
module frame_ring_addr
  import vdma_addr_pkg::*;
#(
  parameter int ASIZE          = DEF_ASIZE,
  parameter int BURST_MAP_ADDR = 12800,
  parameter int FRAME_NUM      = 3,
  parameter int LSIZE          = DEF_LSIZE,
  parameter int IWIDTH         = DEF_IWIDTH
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              new_frame,
  input  logic [ASIZE-1:0]  baseaddr,
  input  logic [ASIZE-1:0]  frame_stride,
  input  logic [ASIZE-1:0]  line_stride,
  input  logic [LSIZE-1:0]  vlines,
  input  logic              park,
  input  logic [IWIDTH-1:0] park_index,
  input  logic              burst_done,
  input  logic              tail_done,
  output logic [ASIZE-1:0]  out_addr,
  output logic [IWIDTH-1:0] frame_index,
  output logic [LSIZE-1:0]  line_cnt,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ASIZE-1:0]  BURST_INC = ASIZE'(BURST_MAP_ADDR);
  localparam logic [IWIDTH-1:0] LAST_IDX  = IWIDTH'(FRAME_NUM - 1);

  // ---------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------
  logic nf_edge;
  logic burst_edge;
  logic tail_edge;

  edge_generator #(.MODE("NORMAL")) u_nf_edge (
    .clock (clock),
    .rst_n (rst_n),
    .level (new_frame),
    .pulse (nf_edge)
  );

  edge_generator #(.MODE("NORMAL")) u_burst_edge (
    .clock (clock),
    .rst_n (rst_n),
    .level (burst_done),
    .pulse (burst_edge)
  );

  edge_generator #(.MODE("NORMAL")) u_tail_edge (
    .clock (clock),
    .rst_n (rst_n),
    .level (tail_done),
    .pulse (tail_edge)
  );

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t             state,       state_n;
  logic [ASIZE-1:0]   line_start,  line_start_n;
  logic [ASIZE-1:0]   out_addr_q,  out_addr_n;
  logic [IWIDTH-1:0]  frame_idx_q, frame_idx_n;
  logic [LSIZE-1:0]   line_cnt_q,  line_cnt_n;
  logic [LSIZE-1:0]   vlines_lat,  vlines_lat_n;
  logic               done_q,      done_n;

  // ---------------------------------------------------------------------
  // Buffer base selection. Kept combinational so a new_frame edge loads the
  // correct base on the very clock edge that samples it.
  // ---------------------------------------------------------------------
  logic [IWIDTH-1:0] park_clamped;
  logic [IWIDTH-1:0] sel_idx;
  logic [ASIZE-1:0]  sel_ext;
  logic [ASIZE-1:0]  frame_base;

  assign park_clamped = (park_index > LAST_IDX) ? LAST_IDX : park_index;
  assign sel_idx      = park ? park_clamped : frame_idx_q;
  assign sel_ext      = ASIZE'(sel_idx);
  assign frame_base   = baseaddr + (sel_ext * frame_stride);

  // Line accounting is done one bit wider so line_cnt+1 cannot wrap when
  // vlines is at its maximum.
  logic [LSIZE:0] cnt_plus_one;
  logic           last_line;

  assign cnt_plus_one = {1'b0, line_cnt_q} + (LSIZE+1)'(1);
  assign last_line    = cnt_plus_one >= {1'b0, vlines_lat};

  // ---------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------
  always_comb begin
    state_n      = state;
    line_start_n = line_start;
    out_addr_n   = out_addr_q;
    frame_idx_n  = frame_idx_q;
    line_cnt_n   = line_cnt_q;
    vlines_lat_n = vlines_lat;
    done_n       = 1'b0;

    if (nf_edge) begin
      // Start, or abort/resync of a running frame: the ring position is
      // deliberately left alone so the same buffer is rewritten.
      state_n      = RUN;
      line_start_n = frame_base;
      out_addr_n   = frame_base;
      line_cnt_n   = '0;
      vlines_lat_n = (vlines == '0) ? LSIZE'(1) : vlines;
    end else if (state == RUN) begin
      if (tail_edge) begin
        line_cnt_n = cnt_plus_one[LSIZE-1:0];
        if (!last_line) begin
          line_start_n = line_start + line_stride;
          out_addr_n   = line_start + line_stride;
        end else begin
          // Frame complete: out_addr stays on the last burst address.
          state_n = IDLE;
          done_n  = 1'b1;
          if (!park) begin
            frame_idx_n = (frame_idx_q >= LAST_IDX) ? '0 : frame_idx_q + 1'b1;
          end
        end
      end else if (burst_edge) begin
        out_addr_n = out_addr_q + BURST_INC;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      line_start  <= '0;
      out_addr_q  <= '0;
      frame_idx_q <= '0;
      line_cnt_q  <= '0;
      vlines_lat  <= LSIZE'(1);
      done_q      <= 1'b0;
    end else begin
      state       <= state_n;
      line_start  <= line_start_n;
      out_addr_q  <= out_addr_n;
      frame_idx_q <= frame_idx_n;
      line_cnt_q  <= line_cnt_n;
      vlines_lat  <= vlines_lat_n;
      done_q      <= done_n;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign out_addr    = out_addr_q;
  assign frame_index = frame_idx_q;
  assign line_cnt    = line_cnt_q;
  assign busy        = (state == RUN);
  assign frame_done  = done_q;

endmodule
